// File: rtl/s3g_rx_multi_if.sv
// Byte-input / committed-buffer bundle between the UART receiver, the S3G
// packet receiver and the executor.
interface s3g_rx_multi_if #(
    parameter int MAX_PAYLOAD = 32,
    parameter int LEN_W       = 8
);
    logic [7:0]               rx_data;
    logic                     rx_done;
    logic                     buf_ack;
    logic                     packet_done;
    logic                     packet_error;
    logic [1:0]               error_code;
    logic                     overrun;
    logic [LEN_W-1:0]         payload_len;
    logic                     buffer_valid;
    logic [8*MAX_PAYLOAD-1:0] buf_flat;

    modport master (
        output rx_data, rx_done, buf_ack,
        input  packet_done, packet_error, error_code, overrun,
        input  payload_len, buffer_valid, buf_flat
    );

    modport slave (
        input  rx_data, rx_done, buf_ack,
        output packet_done, packet_error, error_code, overrun,
        output payload_len, buffer_valid, buf_flat
    );
endinterface

// File: rtl/s3g_rx_multi.sv
// S3G packet receiver: frames 0xD5, length, payload, CRC8 (Maxim, reflected)
// and publishes the last good payload on a flat, acknowledged buffer.
module s3g_rx_multi #(
    parameter int MAX_PAYLOAD    = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int LEN_W          = 8
) (
    input  logic          clk,
    input  logic          rst,
    s3g_rx_multi_if.slave bus
);
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]       MAX_LEN  = 9'(MAX_PAYLOAD);
    localparam logic [7:0]       SYNC     = 8'hD5;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CRC} state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    state_t                   r_state;
    logic [7:0]               r_len;
    logic [7:0]               r_idx;
    logic [7:0]               r_crc;
    logic [TMO_W-1:0]         r_tmo;
    logic [7:0]               r_working [MAX_PAYLOAD];
    logic [8*MAX_PAYLOAD-1:0] r_buf_flat;
    logic [LEN_W-1:0]         r_payload_len;
    logic                     r_buffer_valid;
    logic                     r_packet_done;
    logic                     r_packet_error;
    logic                     r_overrun;
    logic [1:0]               r_error_code;

    state_t                   w_state_nxt;
    logic [7:0]               w_len_nxt;
    logic [7:0]               w_idx_nxt;
    logic [7:0]               w_crc_nxt;
    logic [TMO_W-1:0]         w_tmo_nxt;
    logic                     w_wr_en;
    logic                     w_commit;
    logic                     w_abort;
    logic [1:0]               w_abort_code;
    logic [8*MAX_PAYLOAD-1:0] w_commit_buf;

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_idx_nxt    = r_idx;
        w_crc_nxt    = r_crc;
        w_tmo_nxt    = r_tmo;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_abort      = 1'b0;
        w_abort_code = 2'd0;

        if (bus.rx_done) begin
            // An accepted byte always restarts the inter-byte timer, even on the expiry cycle.
            w_tmo_nxt = '0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.rx_data == SYNC) w_state_nxt = S_LEN;
                end
                S_LEN: begin
                    w_len_nxt = bus.rx_data;
                    w_crc_nxt = 8'h00;
                    w_idx_nxt = 8'd0;
                    if ({1'b0, bus.rx_data} > MAX_LEN) begin
                        w_abort      = 1'b1;
                        w_abort_code = 2'd2;
                        w_state_nxt  = S_IDLE;
                    end else if (bus.rx_data == 8'd0) begin
                        w_state_nxt = S_CRC;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_wr_en   = 1'b1;
                    w_crc_nxt = crc8_step(r_crc, bus.rx_data);
                    w_idx_nxt = r_idx + 8'd1;
                    if (r_idx == r_len - 8'd1) w_state_nxt = S_CRC;
                end
                S_CRC: begin
                    w_state_nxt = S_IDLE;
                    if (bus.rx_data == r_crc) begin
                        w_commit = 1'b1;
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = 2'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state == S_IDLE) begin
            w_tmo_nxt = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (r_tmo == TMO_LAST) begin
                w_abort      = 1'b1;
                w_abort_code = 2'd3;
                w_state_nxt  = S_IDLE;
                w_tmo_nxt    = '0;
            end else begin
                w_tmo_nxt = r_tmo + 1'b1;
            end
        end
    end

    // Bytes past the committed length are zeroed so stale data never leaks to the executor.
    always_comb begin
        w_commit_buf = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (8'(i) < r_len) w_commit_buf[8*i +: 8] = r_working[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_crc   <= '0;
            r_tmo   <= '0;
            for (int i = 0; i < MAX_PAYLOAD; i++) r_working[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_crc   <= w_crc_nxt;
            r_tmo   <= w_tmo_nxt;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                if (w_wr_en && r_idx == 8'(i)) r_working[i] <= bus.rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_flat     <= '0;
            r_payload_len  <= '0;
            r_buffer_valid <= 1'b0;
            r_packet_done  <= 1'b0;
            r_packet_error <= 1'b0;
            r_overrun      <= 1'b0;
            r_error_code   <= 2'd0;
        end else begin
            r_packet_done  <= w_commit;
            r_packet_error <= w_abort;
            r_overrun      <= w_commit && r_buffer_valid && !bus.buf_ack;
            if (w_commit) begin
                r_buf_flat    <= w_commit_buf;
                r_payload_len <= LEN_W'(r_len);
                r_error_code  <= 2'd0;
            end else if (w_abort) begin
                r_error_code  <= w_abort_code;
            end
            // A commit landing with an acknowledge keeps the buffer valid.
            if (w_commit)         r_buffer_valid <= 1'b1;
            else if (bus.buf_ack) r_buffer_valid <= 1'b0;
        end
    end

    assign bus.packet_done  = r_packet_done;
    assign bus.packet_error = r_packet_error;
    assign bus.overrun      = r_overrun;
    assign bus.error_code   = r_error_code;
    assign bus.payload_len  = r_payload_len;
    assign bus.buffer_valid = r_buffer_valid;
    assign bus.buf_flat     = r_buf_flat;
endmodule

// File: tb/tb_s3g_rx_multi.sv
// Scoreboard bench for s3g_rx_multi: packet-level stimulus pushes expected
// events; a negedge monitor pops and compares on every pulse.
module tb_s3g_rx_multi;
    localparam int MP  = 32;
    localparam int TMO = 20;
    localparam int BW  = 8 * MP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s3g_rx_multi_if #(.MAX_PAYLOAD(MP), .LEN_W(8)) bus ();

    s3g_rx_multi #(.MAX_PAYLOAD(MP), .TIMEOUT_CYCLES(TMO), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        bit            done;
        logic [1:0]    code;
        bit            ovr;
        int            len;
        logic [BW-1:0] bf;
        bit            bv;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            checks   = 0;
    int            errors   = 0;
    int            cyc      = 0;
    int            last_cyc = 0;
    logic [BW-1:0] m_buf;
    int            m_len;
    bit            m_valid;
    logic [7:0]    pl [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC: Maxim/iButton reflected CRC8 over pl[0..n-1].
    function automatic logic [7:0] crc_of(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            c = c ^ int'(pl[i]);
            for (int k = 0; k < 8; k++) c = (c % 2 == 1) ? ((c / 2) ^ 'h8C) : (c / 2);
        end
        return 8'(c);
    endfunction

    function automatic logic [BW-1:0] buf_of(input int n);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[8*i +: 8] = pl[i];
        return b;
    endfunction

    function automatic logic [7:0] garbage();
        logic [7:0] g;
        g = 8'($urandom);
        return (g == 8'hD5) ? 8'h00 : g;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        last_cyc    = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.rx_done = 1'b0;
        end
    endtask

    task automatic push(input bit done, input logic [1:0] code, input bit ovr, input int c);
        exp_t e;
        e.done = done; e.code = code; e.ovr = ovr;
        e.len = m_len; e.bf = m_buf; e.bv = m_valid; e.cyc = c;
        q.push_back(e);
    endtask

    // mode 0: good CRC, mode 1: corrupted CRC.
    task automatic packet(input int len, input int mode, input bit ack_last, input int maxgap, input bit rnd);
        logic [7:0] c;
        bit         ovr;
        if (rnd) for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
        c = crc_of(len);
        if (mode == 1) c = c ^ 8'($urandom_range(1, 255));
        send_byte(8'hD5);
        idle($urandom_range(0, maxgap));
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            idle($urandom_range(0, maxgap));
            send_byte(pl[i]);
        end
        idle($urandom_range(0, maxgap));
        send_byte(c);
        bus.buf_ack = ack_last && (mode == 0);
        if (mode == 0) begin
            ovr     = m_valid && !ack_last;
            m_buf   = buf_of(len);
            m_len   = len;
            m_valid = 1'b1;
            push(1'b1, 2'd0, ovr, last_cyc + 1);
        end else begin
            push(1'b0, 2'd1, 1'b0, last_cyc + 1);
        end
        idle(1);
        bus.buf_ack = 1'b0;
        idle(2);
    endtask

    task automatic too_long(input int len, input int ngarb);
        send_byte(8'hD5);
        send_byte(8'(len));
        push(1'b0, 2'd2, 1'b0, last_cyc + 1);
        for (int i = 0; i < ngarb; i++) begin
            idle($urandom_range(0, 2));
            send_byte(garbage());
        end
        idle(2);
    endtask

    task automatic timeout_pkt(input bit send_len, input int len, input int nb);
        send_byte(8'hD5);
        if (send_len) begin
            send_byte(8'(len));
            for (int i = 0; i < nb; i++) send_byte(pl[i]);
        end
        push(1'b0, 2'd3, 1'b0, last_cyc + 1 + TMO);
        idle(TMO + 3);
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        bus.buf_ack = 1'b1;
        @(posedge clk); #1;
        bus.buf_ack = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", BW'(bus.buffer_valid), BW'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buf_flat"},     bus.buf_flat,             '0);
        chk({tag, "_payload_len"},  BW'(bus.payload_len),     BW'(0));
        chk({tag, "_buffer_valid"}, BW'(bus.buffer_valid),    BW'(0));
        chk({tag, "_error_code"},   BW'(bus.error_code),      BW'(0));
        chk({tag, "_pulses"},       BW'({bus.packet_done, bus.packet_error, bus.overrun}), BW'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.packet_done || bus.packet_error)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0d error=%0d code=%0d, required no pulse (cycle %0d)",
                         bus.packet_done, bus.packet_error, bus.error_code, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("packet_done",  BW'(bus.packet_done),  BW'(mon_e.done));
                chk("packet_error", BW'(bus.packet_error), BW'(!mon_e.done));
                chk("error_code",   BW'(bus.error_code),   BW'(mon_e.code));
                chk("overrun",      BW'(bus.overrun),      BW'(mon_e.ovr));
                chk("payload_len",  BW'(bus.payload_len),  BW'(mon_e.len));
                chk("buf_flat",     bus.buf_flat,          mon_e.bf);
                chk("buffer_valid", BW'(bus.buffer_valid), BW'(mon_e.bv));
                chk("pulse_cycle",  BW'(cyc),              BW'(mon_e.cyc));
            end
        end else if (rst_n && bus.overrun) begin
            checks++;
            errors++;
            $display("FAIL lone_overrun: overrun=1 without packet_done, required 0 (cycle %0d)", cyc);
        end
    end

    initial begin
        int kind;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.buf_ack = 1'b0;
        m_buf   = '0;
        m_len   = 0;
        m_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Garbage then D5 03 01 02 03 <crc>.
        send_byte(8'h0D);
        idle(1);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        packet(3, 0, 1'b0, 0, 1'b0);
        // Same payload, corrupted CRC.
        packet(3, 1, 1'b0, 0, 1'b0);
        // Overrun on a second good packet without acknowledge.
        pl[0] = 8'h00; pl[1] = 8'h01; pl[2] = 8'h02;
        packet(3, 0, 1'b0, 1, 1'b0);
        do_ack();
        // Over-long length, garbage, then empty packet.
        too_long(33, 4);
        packet(0, 0, 1'b0, 0, 1'b0);
        // Timeout inside payload, then the completed packet.
        pl[0] = 8'h3D; pl[1] = 8'h0D;
        timeout_pkt(1'b1, 2, 1);
        packet(2, 0, 1'b0, 0, 1'b0);
        // Back-to-back bytes, maximum length, commit with simultaneous ack.
        pl[0] = 8'hFF;
        packet(1, 0, 1'b0, 0, 1'b0);
        packet(MP, 0, 1'b0, 0, 1'b1);
        packet($urandom_range(1, MP), 0, 1'b1, 1, 1'b1);
        timeout_pkt(1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1: packet($urandom_range(0, MP), 0, $urandom_range(0, 3) == 0, 3, 1'b1);
                2: packet($urandom_range(0, MP), 1, 1'b0, 3, 1'b1);
                3: too_long($urandom_range(MP + 1, 255), $urandom_range(0, 4));
                4: begin
                    int l;
                    l = $urandom_range(0, MP);
                    for (int i = 0; i < l; i++) pl[i] = 8'($urandom);
                    timeout_pkt(1'b1, l, $urandom_range(0, l));
                end
                5: begin
                    for (int i = 0; i < 3; i++) send_byte(garbage());
                    idle(2);
                end
                default: do_ack();
            endcase
        end

        // Reset in the middle of a payload.
        packet(4, 0, 1'b0, 0, 1'b1);
        send_byte(8'hD5);
        send_byte(8'd8);
        send_byte(8'h55);
        send_byte(8'h66);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        bus.rx_done = 1'b0;
        m_buf   = '0;
        m_len   = 0;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(TMO + 5);
        packet($urandom_range(1, MP), 0, 1'b0, 2, 1'b1);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/s3g_rx_multi.md
Name: s3g_rx_multi

Overview:
Parametrised S3G packet receiver, successor to the fixed 16-byte receiver. It takes bytes from the UART receiver (rx_data/rx_done) and frames packets as 0xD5, length, payload, CRC8. It checks the CRC and exposes the last good payload on a double-buffered flat bus to the executor. Additions over the fixed receiver:
- configurable payload depth;
- inter-byte timeout;
- error classification;
- consumer acknowledge with overrun detection.

Parameters:
MAX_PAYLOAD, 32, payload buffer depth in bytes (1..255); longer length fields are rejected.
TIMEOUT_CYCLES, 65535, maximum clk cycles between bytes inside a packet; 0 disables the timeout.
LEN_W, 8, width of payload_len (fixed by protocol; exposed for the executor).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
rx_data  in  8  received byte; valid when rx_done=1
rx_done  in  1  one-cycle strobe, one byte per strobe
buf_ack  in  1  consumer has taken the buffer; clears buffer_valid
packet_done  out  1  one-cycle pulse: good packet committed
packet_error  out  1  one-cycle pulse: packet aborted
error_code  out  2  cause of last error: 0 none, 1 crc, 2 length>MAX_PAYLOAD, 3 timeout; held until next packet_done/packet_error
overrun  out  1  one-cycle pulse with packet_done when buffer_valid was still set
payload_len  out  8  length of committed payload
buffer_valid  out  1  committed buffer holds an unacknowledged good packet
buf_flat  out  8*MAX_PAYLOAD  committed payload; byte i at [8i+7:8i]

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE;
  - all outputs 0, including buf_flat, payload_len and error_code;
  - working buffer, CRC register and timeout counter 0.
- States: IDLE, LEN, PAYLOAD, CRC. Only cycles with rx_done=1 advance the state.
- IDLE:
  - byte 0xD5 -> LEN;
  - any other byte is discarded silently, with no error pulse.
- LEN:
  - latch length L and clear CRC to 0x00;
  - L > MAX_PAYLOAD -> error code 2, back to IDLE, remaining bytes are hunted through as garbage;
  - L == 0 -> CRC;
  - otherwise -> PAYLOAD with index 0.
- PAYLOAD:
  - write the byte to working[index] and fold it into the CRC;
  - after index L-1 -> CRC.
- CRC byte handling (rx_done in state CRC): compare the received byte with the computed CRC, then return to IDLE.
  - Equal -> commit: copy working[0..L-1] to buf_flat, zero buf_flat bytes L..MAX_PAYLOAD-1, set payload_len=L.
  - Unequal -> error code 1; buf_flat, payload_len and buffer_valid are unchanged.
- CRC algorithm is Maxim/iButton CRC8, reflected:
  - crc ^= byte;
  - repeat 8 times: crc = crc[0] ? (crc>>1)^0x8C : crc>>1.
  - Computed combinationally in the same cycle the byte is accepted.
- Latency: packet_done, packet_error and overrun are registered and pulse exactly one cycle, in the cycle after the rx_done that completes or aborts the packet. buf_flat, payload_len and buffer_valid update in that same cycle.
- buffer_valid:
  - set on commit;
  - cleared by buf_ack=1;
  - commit and buf_ack in the same cycle -> stays 1 (the commit wins).
- overrun: commit while buffer_valid=1 (and no buf_ack that cycle) -> overrun=1 with packet_done; the new packet still overwrites the buffer.
- Timeout:
  - counter clears on every rx_done and holds 0 in IDLE;
  - in LEN/PAYLOAD/CRC it increments each cycle without rx_done;
  - reaching TIMEOUT_CYCLES -> error code 3, packet_error pulse, back to IDLE;
  - rx_done in the same cycle as expiry -> the byte wins and the counter clears.
- A 0xD5 byte inside LEN/PAYLOAD/CRC is ordinary data; there is no resynchronisation except by error or timeout.
- Reset mid-packet: the partial packet is lost, with no pulses; buf_flat is cleared.
- rx_done pulses arriving on consecutive cycles are each accepted; no back-pressure.

Test Plan:
- Garbage 0x0D, then D5 03 01 02 03 D8 -> packet_done pulse one cycle after the last byte; payload_len=3; buf_flat[23:0]=0x030201; buffer_valid=1; error_code=0.
- D5 03 01 02 03 CC after a good packet -> packet_error pulse, error_code=1; buf_flat and payload_len are unchanged.
- D5 03 00 01 02 78 with no buf_ack since the previous good packet -> packet_done and overrun together; buf_flat[23:0]=0x020100.
  - Then assert buf_ack -> buffer_valid=0 next cycle.
- D5 21 (33 > MAX_PAYLOAD=32) -> packet_error, error_code=2. The following bytes are ignored until the next D5. Then D5 00 00 -> packet_done, payload_len=0, buf_flat all zero.
- With TIMEOUT_CYCLES=20: send D5 02 3D, then idle 20 cycles -> packet_error, error_code=3, state IDLE. The next D5 02 3D 0D 59 is framed correctly (CRC match by computation).
- Back-to-back rx_done every cycle for D5 01 FF 35 -> packet_done. Also: assert rst low mid-payload -> all outputs 0 immediately, with no pulses afterwards.
